sdr_init_seq: RTL and testbench

SDR_INIT_SEQ -- requirements
Module: sdr_init_seq

---
 rtl/sdr_init_seq.sv | 159 +++++++++++++++
 tb/tb_sdr_init_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sdr_init_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | sdr_init_seq : SDRAM power-up init sequencer (NOP wait, PRECHARGE ALL,      |
// |   REF_CNT x AUTO_REFRESH, LOAD_MODE_REG, done). Option: SDR_INIT_REINIT_EN   |
// |   enables re-initialisation from DONE via sdr_init_req.                     |
// | Rev 1.0 - initial release                                                   |
// +-----------------------------------------------------------------------------+
module sdr_init_seq #(
  parameter int PWRUP_CYC = 10000,
  parameter int TRP_CYC   = 8,
  parameter int TRFC_CYC  = 10,
  parameter int REF_CNT   = 16,
  parameter int TMRD_CYC  = 18
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic [2:0]  cfg_sdr_cas,
  input  logic [2:0]  cfg_sdr_bl,
  input  logic        sdr_init_req,
  output logic        sdr_cs_n,
  output logic        sdr_ras_n,
  output logic        sdr_cas_n,
  output logic        sdr_we_n,
  output logic [12:0] sdr_addr,
  output logic [1:0]  sdr_ba,
  output logic        sdr_init_done
);

  localparam int MAX_AB  = (PWRUP_CYC > TRP_CYC) ? PWRUP_CYC : TRP_CYC;
  localparam int MAX_CD  = (TRFC_CYC > TMRD_CYC) ? TRFC_CYC : TMRD_CYC;
  localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  // Wait-state loads are interval-2: the command cycle and the exit cycle
  // both belong to the interval, so every timing parameter must be >= 2.
  localparam logic [CNT_W-1:0] PWRUP_LOAD = CNT_W'(PWRUP_CYC);
  localparam logic [CNT_W-1:0] TRP_LOAD   = CNT_W'(TRP_CYC - 2);
  localparam logic [CNT_W-1:0] TRFC_LOAD  = CNT_W'(TRFC_CYC - 2);
  localparam logic [CNT_W-1:0] TMRD_LOAD  = CNT_W'(TMRD_CYC - 2);
  localparam logic [7:0]       REF_LAST   = 8'(REF_CNT);

  localparam logic [3:0]  CMD_INHIBIT = 4'b1111;
  localparam logic [3:0]  CMD_NOP     = 4'b0111;
  localparam logic [3:0]  CMD_PRE     = 4'b0010;
  localparam logic [3:0]  CMD_REF     = 4'b0001;
  localparam logic [3:0]  CMD_LMR     = 4'b0000;
  localparam logic [12:0] ADDR_PALL   = 13'h0400;

  typedef enum logic [2:0] {
    ST_PWRUP     = 3'd0,
    ST_PRE       = 3'd1,
    ST_TRP_WAIT  = 3'd2,
    ST_REF       = 3'd3,
    ST_TRFC_WAIT = 3'd4,
    ST_MRS       = 3'd5,
    ST_TMRD_WAIT = 3'd6,
    ST_DONE      = 3'd7
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       ref_cnt;
  logic [3:0]       cmd;

  assign {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} = cmd;

`ifndef SDR_INIT_REINIT_EN
  logic unused_init_req;
  assign unused_init_req = sdr_init_req;
`endif

  // The state register always names the command currently on the bus.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state         <= ST_PWRUP;
      cnt           <= PWRUP_LOAD;
      ref_cnt       <= '0;
      cmd           <= CMD_INHIBIT;
      sdr_addr      <= '0;
      sdr_ba        <= '0;
      sdr_init_done <= 1'b0;
    end else begin
      cmd      <= CMD_NOP;
      sdr_addr <= '0;
      sdr_ba   <= '0;
      case (state)
        ST_PWRUP: begin
          if (cnt == '0) begin
            state    <= ST_PRE;
            cmd      <= CMD_PRE;
            sdr_addr <= ADDR_PALL;
            ref_cnt  <= '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_PRE: begin
          state <= ST_TRP_WAIT;
          cnt   <= TRP_LOAD;
        end
        ST_TRP_WAIT: begin
          if (cnt == '0) begin
            state   <= ST_REF;
            cmd     <= CMD_REF;
            ref_cnt <= ref_cnt + 8'd1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_REF: begin
          state <= ST_TRFC_WAIT;
          cnt   <= TRFC_LOAD;
        end
        ST_TRFC_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (ref_cnt == REF_LAST) begin
            state    <= ST_MRS;
            cmd      <= CMD_LMR;
            sdr_addr <= {6'b000000, cfg_sdr_cas, 1'b0, cfg_sdr_bl};
          end else begin
            state   <= ST_REF;
            cmd     <= CMD_REF;
            ref_cnt <= ref_cnt + 8'd1;
          end
        end
        ST_MRS: begin
          state <= ST_TMRD_WAIT;
          cnt   <= TMRD_LOAD;
        end
        ST_TMRD_WAIT: begin
          if (cnt == '0) begin
            state         <= ST_DONE;
            sdr_init_done <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: begin
`ifdef SDR_INIT_REINIT_EN
          if (sdr_init_req) begin
            state         <= ST_PRE;
            cmd           <= CMD_PRE;
            sdr_addr      <= ADDR_PALL;
            ref_cnt       <= '0;
            sdr_init_done <= 1'b0;
          end
`endif
        end
        default: begin
          state <= ST_PWRUP;
          cnt   <= PWRUP_LOAD;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sdr_init_seq.sv
`default_nettype none
// tb_sdr_init_seq: two instances (default timing and a short profile) checked
// every cycle against a cycle-index timing model plus literal anchor points.
module tb_sdr_init_seq;

  localparam int A_PW = 10000, A_TRP = 8, A_TRFC = 10, A_RC = 16, A_TMRD = 18;
  localparam int B_PW = 20, B_TRP = 3, B_TRFC = 4, B_RC = 2, B_TMRD = 2;
  localparam int B_DONE = 33;
`ifdef SDR_INIT_REINIT_EN
  localparam bit REINIT = 1'b1;
`else
  localparam bit REINIT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, req_a, req_b;
  logic [2:0]  cas_a, bl_a, cas_b, bl_b;
  logic        cs_a, ras_a, casn_a, we_a, done_a;
  logic        cs_b, ras_b, casn_b, we_b, done_b;
  logic [12:0] addr_a, addr_b;
  logic [1:0]  ba_a, ba_b;
  logic [3:0]  cmd_a, cmd_b;
  logic [12:0] lit_mrs_a;

  assign cmd_a = {cs_a, ras_a, casn_a, we_a};
  assign cmd_b = {cs_b, ras_b, casn_b, we_b};

  int n_checks = 0;
  int n_fail   = 0;

  sdr_init_seq dut_a (
    .sys_clk(clk), .reset(rst_a), .cfg_sdr_cas(cas_a), .cfg_sdr_bl(bl_a),
    .sdr_init_req(req_a), .sdr_cs_n(cs_a), .sdr_ras_n(ras_a), .sdr_cas_n(casn_a),
    .sdr_we_n(we_a), .sdr_addr(addr_a), .sdr_ba(ba_a), .sdr_init_done(done_a)
  );

  sdr_init_seq #(
    .PWRUP_CYC(B_PW), .TRP_CYC(B_TRP), .TRFC_CYC(B_TRFC), .REF_CNT(B_RC), .TMRD_CYC(B_TMRD)
  ) dut_b (
    .sys_clk(clk), .reset(rst_b), .cfg_sdr_cas(cas_b), .cfg_sdr_bl(bl_b),
    .sdr_init_req(req_b), .sdr_cs_n(cs_b), .sdr_ras_n(ras_b), .sdr_cas_n(casn_b),
    .sdr_we_n(we_b), .sdr_addr(addr_b), .sdr_ba(ba_b), .sdr_init_done(done_b)
  );

  // Expected {done, cmd[3:0], addr[12:0]} for cycle k counted from reset release.
  function automatic logic [17:0] model(input int k, input int pw, input int trp,
                                        input int trfc, input int rc, input int tmrd,
                                        input logic [2:0] cas, input logic [2:0] bl);
    int mrs, d;
    logic [3:0]  c;
    logic [12:0] a;
    mrs = pw + trp + rc * trfc;
    d   = k - pw - trp;
    c   = 4'b0111;
    a   = '0;
    if (k == pw) begin
      c = 4'b0010; a = 13'h400;
    end else if (d >= 0 && (d % trfc) == 0 && (d / trfc) < rc) begin
      c = 4'b0001;
    end else if (k == mrs) begin
      c = 4'b0000; a = {6'b0, cas, 1'b0, bl};
    end
    return {(k >= mrs + tmrd), c, a};
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got 0x%0h, want 0x%0h", nm, k, act, exp);
    end
  endtask

  initial begin : cmp_a
    int k; bit valid; bit in_rst;
    logic [17:0] e;
    k = 0; valid = 0; in_rst = 0;
    forever begin
      @(posedge clk);
      if (rst_a) begin
        valid = 1; in_rst = 1;
      end else if (valid) begin
        k = in_rst ? 0 : k + 1;
        in_rst = 0;
      end
      #1;
      if (valid) begin
        if (in_rst) begin
          chk("a_rst_out", -1, {13'b0, cmd_a, addr_a, ba_a, done_a}, {13'b0, 4'hF, 13'h0, 2'b0, 1'b0});
        end else begin
          e = model(k, A_PW, A_TRP, A_TRFC, A_RC, A_TMRD, cas_a, bl_a);
          chk("a_cmd",  k, {28'b0, cmd_a}, {28'b0, e[16:13]});
          chk("a_addr", k, {19'b0, addr_a}, {19'b0, e[12:0]});
          chk("a_ba",   k, {30'b0, ba_a}, 32'd0);
          chk("a_done", k, {31'b0, done_a}, {31'b0, e[17]});
          if (k == 9999)  chk("a_lit_nop_last", k, {28'b0, cmd_a}, 32'h7);
          if (k == 10000) chk("a_lit_pre", k, {15'b0, cmd_a, addr_a}, {15'b0, 4'b0010, 13'h400});
          if (k == 10008) chk("a_lit_ref1", k, {28'b0, cmd_a}, 32'h1);
          if (k == 10158) chk("a_lit_ref16", k, {28'b0, cmd_a}, 32'h1);
          if (k == 10168) chk("a_lit_mrs", k, {15'b0, cmd_a, addr_a}, {15'b0, 4'b0000, lit_mrs_a});
          if (k == 10185) chk("a_lit_done_lo", k, {31'b0, done_a}, 32'd0);
          if (k == 10186) chk("a_lit_done_hi", k, {31'b0, done_a}, 32'd1);
        end
      end
    end
  end

  initial begin : cmp_b
    int k; bit valid; bit in_rst; int refs;
    logic [17:0] e;
    k = 0; valid = 0; in_rst = 0; refs = 0;
    forever begin
      @(posedge clk);
      if (rst_b) begin
        valid = 1; in_rst = 1;
      end else if (valid) begin
        if (in_rst) k = 0;
        else if (REINIT && req_b && k >= B_DONE) k = B_PW;
        else k = k + 1;
        in_rst = 0;
        if (k == 0 || k == B_PW) refs = 0;
      end
      #1;
      if (valid) begin
        if (in_rst) begin
          chk("b_rst_out", -1, {13'b0, cmd_b, addr_b, ba_b, done_b}, {13'b0, 4'hF, 13'h0, 2'b0, 1'b0});
        end else begin
          e = model(k, B_PW, B_TRP, B_TRFC, B_RC, B_TMRD, cas_b, bl_b);
          chk("b_cmd",  k, {28'b0, cmd_b}, {28'b0, e[16:13]});
          chk("b_addr", k, {19'b0, addr_b}, {19'b0, e[12:0]});
          chk("b_ba",   k, {30'b0, ba_b}, 32'd0);
          chk("b_done", k, {31'b0, done_b}, {31'b0, e[17]});
          if (cmd_b == 4'b0001) refs++;
          if (k == 20) chk("b_lit_pre", k, {15'b0, cmd_b, addr_b}, {15'b0, 4'b0010, 13'h400});
          if (k == 23) chk("b_lit_ref1", k, {28'b0, cmd_b}, 32'h1);
          if (k == 27) chk("b_lit_ref2", k, {28'b0, cmd_b}, 32'h1);
          if (k == 31) chk("b_lit_mrs", k, {15'b0, cmd_b, addr_b}, {15'b0, 4'b0000, 13'h020});
          if (k == 32) chk("b_lit_done_lo", k, {31'b0, done_b}, 32'd0);
          if (k == 33) chk("b_lit_done_hi", k, {31'b0, done_b}, 32'd1);
          if (k == 33) chk("b_ref_count", k, refs, 32'd2);
        end
      end
    end
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; req_a = 1'b0; req_b = 1'b0;
    cas_a = 3'd3; bl_a = 3'b011; lit_mrs_a = 13'h033;
    cas_b = 3'd2; bl_b = 3'b000;
    fork
      begin : stim_a
        repeat (4) @(negedge clk);
        rst_a = 1'b0;
        // one-cycle reset sampled at cycle 10050, inside the 5th tRFC wait
        repeat (10050) @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        repeat (10200) @(negedge clk);
        cas_a = 3'd2; bl_a = 3'b000; lit_mrs_a = 13'h020;
        rst_a = 1'b1;
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        repeat (10200) @(negedge clk);
      end
      begin : stim_b
        repeat (4) @(negedge clk);
        rst_b = 1'b0;
        // request sampled 5 cycles after done rises
        repeat (38) @(negedge clk);
        req_b = 1'b1;
        @(negedge clk);
        req_b = 1'b0;
        repeat (50) @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        // request during power-up wait must be ignored
        repeat (10) @(negedge clk);
        req_b = 1'b1;
        @(negedge clk);
        req_b = 1'b0;
        repeat (25) @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        repeat (60) @(negedge clk);
      end
    join
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
